// File: rtl/lpc_frame_fifo.sv
// Frame-aware AXI-Stream buffer for the LPC decoder path: {TLAST, DATA} share one
// memory, with an optional packet mode that holds words back until a full frame is stored.
module lpc_frame_fifo #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 128,
  parameter int AF_THRESH  = DEPTH - 4
) (
  input  logic                           ACLK,
  input  logic                           ARESET_N,
  input  logic [DATA_WIDTH-1:0]          S_TDATA,
  input  logic                           S_TLAST,
  input  logic                           S_TVALID,
  output logic                           S_TREADY,
  output logic [DATA_WIDTH-1:0]          M_TDATA,
  output logic                           M_TLAST,
  output logic                           M_TVALID,
  input  logic                           M_TREADY,
  input  logic                           FRAME_MODE,
  input  logic                           FLUSH,
  output logic [$clog2(DEPTH+1)-1:0]     COUNT,
  output logic [$clog2(DEPTH+1)-1:0]     FRAME_COUNT,
  output logic                           ALMOST_FULL,
  output logic                           DBG_CUT
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] C_FULL    = CW'(DEPTH);
  localparam logic [CW-1:0] C_AF      = CW'(AF_THRESH);
  localparam logic [CW-1:0] C_CNT_ONE = CW'(1);
  localparam logic [AW-1:0] C_PTR_ONE = AW'(1);

  logic [DATA_WIDTH:0] r_mem [DEPTH];
  logic [AW-1:0]       r_wptr;
  logic [AW-1:0]       r_rptr;
  logic [CW-1:0]       r_count;
  logic [CW-1:0]       r_frame_count;
  logic                r_cut;
  logic                r_ready_en;

  logic                w_full;
  logic                w_empty;
  logic [DATA_WIDTH:0] w_head;
  logic                w_wr;
  logic                w_rd;
  logic                w_wr_last;
  logic                w_rd_last;

  // Handshakes: a word moves on an edge only when valid & ready are both high in the
  // cycle before it; valid never waits on ready, and FLUSH discards both sides.
  assign w_full    = (r_count == C_FULL);
  assign w_empty   = (r_count == '0);
  assign w_head    = r_mem[r_rptr];

  assign S_TREADY  = ~w_full & ~FLUSH & r_ready_en;
  assign M_TDATA   = w_head[DATA_WIDTH-1:0];
  assign M_TLAST   = w_head[DATA_WIDTH];
  assign M_TVALID  = ~w_empty & (~FRAME_MODE | (r_frame_count != '0) | r_cut);

  assign w_wr      = S_TVALID & S_TREADY;
  assign w_rd      = M_TVALID & M_TREADY & ~FLUSH;
  assign w_wr_last = w_wr & S_TLAST;
  assign w_rd_last = w_rd & M_TLAST;

  assign COUNT       = r_count;
  assign FRAME_COUNT = r_frame_count;
  assign ALMOST_FULL = (r_count >= C_AF);
  assign DBG_CUT     = r_cut;

  always_ff @(posedge ACLK) begin
    if (w_wr) begin
      r_mem[r_wptr] <= {S_TLAST, S_TDATA};
    end
  end

  always_ff @(posedge ACLK or negedge ARESET_N) begin
    if (!ARESET_N) begin
      r_wptr        <= '0;
      r_rptr        <= '0;
      r_count       <= '0;
      r_frame_count <= '0;
      r_cut         <= 1'b0;
      r_ready_en    <= 1'b0;
    end else begin
      r_ready_en <= 1'b1;
      if (FLUSH) begin
        r_wptr        <= '0;
        r_rptr        <= '0;
        r_count       <= '0;
        r_frame_count <= '0;
        r_cut         <= 1'b0;
      end else begin
        if (w_wr) r_wptr <= r_wptr + C_PTR_ONE;
        if (w_rd) r_rptr <= r_rptr + C_PTR_ONE;

        case ({w_wr, w_rd})
          2'b10:   r_count <= r_count + C_CNT_ONE;
          2'b01:   r_count <= r_count - C_CNT_ONE;
          default: r_count <= r_count;
        endcase

        case ({w_wr_last, w_rd_last})
          2'b10:   r_frame_count <= r_frame_count + C_CNT_ONE;
          2'b01:   r_frame_count <= r_frame_count - C_CNT_ONE;
          default: r_frame_count <= r_frame_count;
        endcase

        // A full buffer with no complete frame can never release in packet mode,
        // so the head frame is allowed to stream through until its TLAST leaves.
        if (w_rd_last) begin
          r_cut <= 1'b0;
        end else if (w_full && (r_frame_count == '0)) begin
          r_cut <= 1'b1;
        end
      end
    end
  end

endmodule
